// File: rtl/fetch_decode_pipe.sv
// -----------------------------------------------------------------------------
// fetch_decode_pipe
//
// Purpose:
//   Front end of a classic 5-stage MIPS-style pipeline. It holds the fetch PC
//   register, the IF/ID pipeline register and the ID/EX pipeline register.
//   The hazard unit drives its stall and flush controls, and decode drives its
//   branch and jump redirects.
//
// Optional feature:
//   STALL_CNT_EN - when defined, adds the StallCnt and FlushCnt outputs. These
//                  are saturating 16-bit counters of StallD and FlushE cycles.
//
// Ports:
//   clk            sole clock; all state updates on the rising edge
//   reset          asynchronous, active-high; clears all state immediately
//   StallF         hold the PC register
//   StallD         hold IF/ID; also blocks redirects and holds the PC
//   FlushE         load a bubble into ID/EX (highest priority for that stage)
//   PCSrcD         branch taken (resolved in decode); PCBranchD is its target
//   jumpD          jump in decode (beats a branch); PCJumpD is its target
//   InstrF         instruction-memory read data for PCF
//   CtrlD          decoded control bundle (CTRL_W bits)
//   RsD/RtD/RdD    decode register fields
//   PCF            fetch PC (instruction-memory address)
//   InstrD         IF/ID contents: instruction
//   PCPlus4D       IF/ID contents: fetch PC + 4
//   ValidD         IF/ID holds a real instruction
//   CtrlE          ID/EX contents: control bundle
//   RsE/RtE/RdE    ID/EX contents: register fields
//   ValidE         ID/EX holds a real instruction
//   StallCnt       StallD cycle count (STALL_CNT_EN only)
//   FlushCnt       FlushE cycle count (STALL_CNT_EN only)
//
// Handshake:
//   There is no valid/ready flow control here. Each stage's Valid bit moves
//   down the pipe alongside its data. Stalls hold a stage, and flushes replace
//   its contents with an all-zero bubble whose Valid bit is 0.
// -----------------------------------------------------------------------------
module fetch_decode_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic [31:0]       PCBranchD,
  input  logic              jumpD,
  input  logic [31:0]       PCJumpD,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]       StallCnt,
  output logic [15:0]       FlushCnt
`endif
);

  // ---------------------------------------------------------------------------
  // Fetch: PC register
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;  // wraps naturally at 2^32

  // The redirect is ignored while decode is stalled, because the branch
  // operands may not yet be forwarded. In that case the PC also holds.
  assign redirect = ~StallD & (jumpD | PCSrcD);

  always_comb begin
    pc_d = pc_q;
    if (!StallF && !StallD) begin
      if (jumpD) begin
        pc_d = PCJumpD;
      end else if (PCSrcD) begin
        pc_d = PCBranchD;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (!StallD) begin
      if (redirect) begin
        // The instruction fetched behind a taken branch/jump is squashed.
        ifid_instr_d = 32'd0;
        ifid_pc4_d   = 32'd0;
        ifid_valid_d = 1'b0;
      end else begin
        // With StallF=1 this captures the same fetch again (a duplicate).
        // The hazard unit is expected never to request that combination.
        ifid_instr_d = InstrF;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register (never stalls; FlushE inserts a bubble)
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0] idex_ctrl_q,  idex_ctrl_d;
  logic [4:0]        idex_rs_q,    idex_rs_d;
  logic [4:0]        idex_rt_q,    idex_rt_d;
  logic [4:0]        idex_rd_q,    idex_rd_d;
  logic              idex_valid_q, idex_valid_d;

  always_comb begin
    idex_ctrl_d  = CtrlD;
    idex_rs_d    = RsD;
    idex_rt_d    = RtD;
    idex_rd_d    = RdD;
    idex_valid_d = ifid_valid_q;
    if (FlushE) begin
      idex_ctrl_d  = '0;
      idex_rs_d    = 5'd0;
      idex_rt_d    = 5'd0;
      idex_rd_d    = 5'd0;
      idex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_ctrl_q  <= '0;
      idex_rs_q    <= 5'd0;
      idex_rt_q    <= 5'd0;
      idex_rd_q    <= 5'd0;
      idex_valid_q <= 1'b0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      idex_valid_q <= idex_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall/flush event counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (FlushE && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PCF      = pc_q;
  assign InstrD   = ifid_instr_q;
  assign PCPlus4D = ifid_pc4_q;
  assign ValidD   = ifid_valid_q;
  assign CtrlE    = idex_ctrl_q;
  assign RsE      = idex_rs_q;
  assign RtE      = idex_rt_q;
  assign RdE      = idex_rd_q;
  assign ValidE   = idex_valid_q;

endmodule
